// File: rtl/peg_scorer_if.sv
// peg_scorer_if: start/busy/done scoring handshake, code/guess pegs and feedback results
interface peg_scorer_if #(
    parameter int COLOR_W = 3
);
    logic               start;
    logic [COLOR_W-1:0] code0;
    logic [COLOR_W-1:0] code1;
    logic [COLOR_W-1:0] code2;
    logic [COLOR_W-1:0] code3;
    logic [COLOR_W-1:0] guess0;
    logic [COLOR_W-1:0] guess1;
    logic [COLOR_W-1:0] guess2;
    logic [COLOR_W-1:0] guess3;
    logic               busy;
    logic               done;
    logic [1:0]         fb0;
    logic [1:0]         fb1;
    logic [1:0]         fb2;
    logic [1:0]         fb3;
    logic [2:0]         exact_count;
    logic [2:0]         partial_count;
    logic               game_over;

    modport master (
        output start, code0, code1, code2, code3, guess0, guess1, guess2, guess3,
        input  busy, done, fb0, fb1, fb2, fb3, exact_count, partial_count, game_over
    );

    modport slave (
        input  start, code0, code1, code2, code3, guess0, guess1, guess2, guess3,
        output busy, done, fb0, fb1, fb2, fb3, exact_count, partial_count, game_over
    );
endinterface

// File: rtl/peg_scorer.sv
// peg_scorer: sequential Mastermind scorer with duplicate-safe exact/partial marking
module peg_scorer #(
    parameter int COLOR_W   = 3,
    parameter int POSITIONS = 4
) (
    input  logic          clk,
    input  logic          reset,
    peg_scorer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, FILL} state_t;

    state_t                 state_q, state_d;
    logic [COLOR_W-1:0]     code_q [POSITIONS];
    logic [COLOR_W-1:0]     code_d [POSITIONS];
    logic [COLOR_W-1:0]     guess_q [POSITIONS];
    logic [COLOR_W-1:0]     guess_d [POSITIONS];
    logic [POSITIONS-1:0]   used_code_q, used_code_d;
    logic [POSITIONS-1:0]   used_guess_q, used_guess_d;
    logic [2:0]             exact_q, exact_d;
    logic [2:0]             partial_q, partial_d;
    logic [1:0]             idx_q, idx_d;
    logic [3:0]             pair_q, pair_d;
    logic                   done_q, done_d;
    logic                   game_over_q, game_over_d;
    logic [2:0]             exact_count_q, exact_count_d;
    logic [2:0]             partial_count_q, partial_count_d;
    logic [1:0]             fb_q [POSITIONS];
    logic [1:0]             fb_d [POSITIONS];

    // State, working registers and published results; reset aborts any score in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            code_q          <= '{default: '0};
            guess_q         <= '{default: '0};
            used_code_q     <= '0;
            used_guess_q    <= '0;
            exact_q         <= '0;
            partial_q       <= '0;
            idx_q           <= '0;
            pair_q          <= '0;
            done_q          <= 1'b0;
            game_over_q     <= 1'b0;
            exact_count_q   <= '0;
            partial_count_q <= '0;
            fb_q            <= '{default: '0};
        end else begin
            state_q         <= state_d;
            code_q          <= code_d;
            guess_q         <= guess_d;
            used_code_q     <= used_code_d;
            used_guess_q    <= used_guess_d;
            exact_q         <= exact_d;
            partial_q       <= partial_d;
            idx_q           <= idx_d;
            pair_q          <= pair_d;
            done_q          <= done_d;
            game_over_q     <= game_over_d;
            exact_count_q   <= exact_count_d;
            partial_count_q <= partial_count_d;
            fb_q            <= fb_d;
        end
    end

    // Snapshot on start, walk positions for exact hits, then every (guess i, code j) pair for colour hits
    always_comb begin
        state_d         = state_q;
        code_d          = code_q;
        guess_d         = guess_q;
        used_code_d     = used_code_q;
        used_guess_d    = used_guess_q;
        exact_d         = exact_q;
        partial_d       = partial_q;
        idx_d           = idx_q;
        pair_d          = pair_q;
        done_d          = 1'b0;
        game_over_d     = game_over_q;
        exact_count_d   = exact_count_q;
        partial_count_d = partial_count_q;
        fb_d            = fb_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    code_d       = '{bus.code0, bus.code1, bus.code2, bus.code3};
                    guess_d      = '{bus.guess0, bus.guess1, bus.guess2, bus.guess3};
                    used_code_d  = '0;
                    used_guess_d = '0;
                    exact_d      = '0;
                    partial_d    = '0;
                    idx_d        = '0;
                    state_d      = EXACT;
                end
            end
            EXACT: begin
                if (guess_q[idx_q] == code_q[idx_q]) begin
                    used_code_d[idx_q]  = 1'b1;
                    used_guess_d[idx_q] = 1'b1;
                    exact_d             = exact_q + 3'd1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    pair_d  = '0;
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (!used_guess_q[pair_q[3:2]] && !used_code_q[pair_q[1:0]] &&
                    guess_q[pair_q[3:2]] == code_q[pair_q[1:0]]) begin
                    used_guess_d[pair_q[3:2]] = 1'b1;
                    used_code_d[pair_q[1:0]]  = 1'b1;
                    partial_d                 = partial_q + 3'd1;
                end
                pair_d  = pair_q + 4'd1;
                state_d = (pair_q == 4'd15) ? FILL : PARTIAL;
            end
            default: begin
                exact_count_d   = exact_q;
                partial_count_d = partial_q;
                game_over_d     = (exact_q == 3'd4);
                for (int k = 0; k < POSITIONS; k++)
                    fb_d[k] = (3'(k) < exact_q) ? 2'b10 :
                              (3'(k) < exact_q + partial_q) ? 2'b01 : 2'b00;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.game_over     = game_over_q;
    assign bus.exact_count   = exact_count_q;
    assign bus.partial_count = partial_count_q;
    assign bus.fb0           = fb_q[0];
    assign bus.fb1           = fb_q[1];
    assign bus.fb2           = fb_q[2];
    assign bus.fb3           = fb_q[3];
endmodule

// File: tb/tb_peg_scorer.sv
// tb_peg_scorer: directed Mastermind scoring vectors checked against a count-based reference model
module tb_peg_scorer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [3:0][2:0] tc = '0;
    logic [3:0][2:0] tg = '0;
    int passed = 0;
    int total = 0;
    int m_rem = 0;
    int pe, pp;
    logic m_done = 1'b0;
    logic m_go = 1'b0;
    int m_e = 0;
    int m_p = 0;
    logic [7:0] m_fb = '0;
    logic m_live = 1'b0;
    logic mid_go;
    int lat;

    peg_scorer_if #(.COLOR_W(3)) bus ();

    assign bus.start  = start;
    assign bus.code0  = tc[0];
    assign bus.code1  = tc[1];
    assign bus.code2  = tc[2];
    assign bus.code3  = tc[3];
    assign bus.guess0 = tg[0];
    assign bus.guess1 = tg[1];
    assign bus.guess2 = tg[2];
    assign bus.guess3 = tg[3];

    peg_scorer #(.COLOR_W(3), .POSITIONS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic void score(input logic [3:0][2:0] c, input logic [3:0][2:0] g,
                                  output int e, output int p);
        int tot;
        e = 0;
        tot = 0;
        for (int k = 0; k < 4; k++) if (c[k] == g[k]) e++;
        for (int col = 0; col < 8; col++) begin
            int nc, ng;
            nc = 0;
            ng = 0;
            for (int k = 0; k < 4; k++) begin
                if (c[k] == 3'(col)) nc++;
                if (g[k] == 3'(col)) ng++;
            end
            tot += (nc < ng) ? nc : ng;
        end
        p = tot - e;
    endfunction

    function automatic logic [7:0] mkfb(input int e, input int p);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[7-2*k -: 2] = (k < e) ? 2'b10 : (k < e + p) ? 2'b01 : 2'b00;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_e    = 0;
            m_p    = 0;
            m_go   = 1'b0;
            m_fb   = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_e    = pe;
                    m_p    = pp;
                    m_go   = (pe == 4);
                    m_fb   = mkfb(pe, pp);
                    m_done = 1'b1;
                end
            end else if (start) begin
                score(tc, tg, pe, pp);
                m_rem = 21;
            end
        end
        m_live = 1'b1;
    end

    always @(negedge clk)
        if (m_live)
            check("cycle", 32'({bus.busy, bus.done, bus.game_over, bus.exact_count,
                                bus.partial_count, bus.fb0, bus.fb1, bus.fb2, bus.fb3}),
                           32'({m_rem > 0, m_done, m_go, 3'(m_e), 3'(m_p), m_fb}));

    task automatic set_pegs(input int c0, c1, c2, c3, g0, g1, g2, g3);
        tc = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
        tg = {3'(g3), 3'(g2), 3'(g1), 3'(g0)};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int chg_at, input logic [3:0][2:0] new_guess);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            if (lat == chg_at) tg = new_guess;
            if (lat == 10) mid_go = bus.game_over;
        end while (!bus.done && lat < 40);
        check("latency", lat, 21);
    endtask

    task automatic check_result(input string name, input int e, input int p,
                                input logic [7:0] fb, input logic go);
        check({name, " exact"}, bus.exact_count, e);
        check({name, " partial"}, bus.partial_count, p);
        check({name, " fb"}, {bus.fb0, bus.fb1, bus.fb2, bus.fb3}, fb);
        check({name, " game_over"}, bus.game_over, go);
    endtask

    initial begin
        int nd;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset outputs", {bus.done, bus.game_over, bus.exact_count, bus.partial_count}, 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1 check("start under reset ignored", bus.busy, 0);

        set_pegs(1, 2, 3, 4, 1, 2, 3, 4);
        pulse_start();
        wait_done(0, tg);
        check_result("win", 4, 0, 8'b10101010, 1'b1);

        set_pegs(1, 2, 3, 4, 0, 0, 0, 0);
        pulse_start();
        wait_done(0, tg);
        check("held game_over mid-score", mid_go, 1);
        check_result("zero", 0, 0, 8'b00000000, 1'b0);

        set_pegs(1, 1, 2, 2, 2, 2, 1, 1);
        pulse_start();
        wait_done(0, tg);
        check_result("swap", 0, 4, 8'b01010101, 1'b0);

        set_pegs(1, 1, 2, 3, 1, 3, 1, 1);
        pulse_start();
        wait_done(0, tg);
        check_result("dup", 1, 2, 8'b10010100, 1'b0);

        set_pegs(5, 5, 5, 5, 5, 0, 0, 0);
        pulse_start();
        wait_done(3, {3'd5, 3'd5, 3'd5, 3'd5});
        check_result("snapshot", 1, 0, 8'b10000000, 1'b0);

        set_pegs(2, 2, 2, 2, 2, 2, 2, 2);
        pulse_start();
        repeat (4) @(posedge clk);
        #1 pulse_start();
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort busy", bus.busy, 0);
        check_result("abort", 0, 0, 8'b00000000, 1'b0);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (bus.done) nd++;
        end
        check("abort no done", nd, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/peg_scorer.md
Name: peg_scorer

Overview:
- Sequential Mastermind scorer that sits directly upstream of the seven-segment converters and driver.
- On `start` it snapshots the secret code (from the PRNG) and the committed guess (from the history block), then counts exact matches and colour-only matches using duplicate-safe marking.
- Produces four 2-bit feedback symbols for the converters, plus exact/partial counts and a `game_over` flag.
- Replaces the free-running compare with a start/busy/done handshake.

Parameters:
- COLOR_W, 3, bit width of one peg colour.
- POSITIONS, 4, number of pegs; fixed at 4, other values unsupported.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to score; honoured only in IDLE.
- code0..code3  input  COLOR_W each  secret code, position 0..3.
- guess0..guess3  input  COLOR_W each  guess to score, position 0..3.
- busy  output  1  high while scoring (not IDLE).
- done  output  1  one-cycle pulse when results update.
- fb0..fb3  output  2 each  feedback symbols: 00 none, 01 partial (white), 10 exact (black); 11 never driven.
- exact_count  output  3  number of exact matches, 0..4.
- partial_count  output  3  number of colour-only matches, 0..4.
- game_over  output  1  high when the last scored guess had exact_count = 4.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - busy, done, game_over = 0.
  - fb0..fb3 = 00; exact_count, partial_count = 0.
  - Internal marks and counters cleared.
  - Reset asserted mid-score aborts the score with no done pulse.
- States: IDLE, EXACT, PARTIAL, FILL.
- IDLE:
  - start = 1 on an edge: snapshot code0..3 and guess0..3 into internal registers.
  - Clear used_code[3:0], used_guess[3:0] and the internal counters; idx = 0; go to EXACT.
  - Inputs changing after the snapshot edge have no effect on the result.
- EXACT, one position per cycle, idx 0..3:
  - If guess[idx] == code[idx]: set used_code[idx] and used_guess[idx], and increment the exact counter.
  - After idx = 3, go to PARTIAL with i = 0, j = 0.
- PARTIAL, one (i, j) pair per cycle, j inner loop, 16 cycles:
  - If !used_guess[i] && !used_code[j] && guess[i] == code[j]: set both marks and increment the partial counter.
  - The marks take effect for the next pair evaluated, which guarantees each code peg and each guess peg is consumed at most once.
  - After (3, 3), go to FILL.
- FILL, 1 cycle, registered outputs:
  - exact_count and partial_count take the counter values.
  - fb positions 0..E-1 = 10, next P positions = 01, remainder = 00 (E = exact, P = partial, E + P ≤ 4).
  - game_over = (E == 4).
  - done = 1 for this single cycle; state returns to IDLE.
- Latency: done and the new outputs are visible 21 clock edges after the edge that sampled start.
- busy is high from the edge after start through the FILL edge, i.e. 21 cycles, and is low in the done cycle.
- start while busy is ignored; it is neither queued nor allowed to restart the score.
- start in the same cycle as done's IDLE return is honoured as a new request.
- Outputs hold their last values between scores. game_over changes only at FILL or reset.
- Simultaneous reset and start: reset wins.
- Counts never exceed 4, so no counter overflow is possible.

Test Plan:
- code=1,2,3,4, guess=1,2,3,4, pulse start -> done exactly 21 edges later; exact=4, partial=0, fb0..3=10,10,10,10, game_over=1.
- code=1,1,2,2, guess=2,2,1,1 -> exact=0, partial=4, fb=01,01,01,01, game_over=0.
- code=1,1,2,3, guess=1,3,1,1 -> exact=1, partial=2, fb=10,01,01,00 (duplicate guess 1 not double-counted).
- code=5,5,5,5, guess=5,0,0,0; then change guess inputs to 5,5,5,5 mid-score -> exact=1, partial=0 (snapshot honoured).
- Pulse start, pulse start again at cycle 5, assert reset at cycle 10 -> second start ignored; no done; all outputs 0, busy=0 the cycle after reset.
- Score a winning guess, then score guess=0,0,0,0 against code=1,2,3,4 -> game_over stays 1 until the second FILL, then 0; exact=0, partial=0, fb all 00.
